fetch_unit: RTL and testbench

//   IF1/IF2 front end of the 6-stage core (IF1->IF2->ID->EX->MEM->WB).

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_skid_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_entry_t    : one fetched instruction plus the PC it was fetched from
//   RESET_PC_DEFAULT : default first fetch address after reset
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO that absorbs instruction words returning from memory while
// the decode stage is stalled.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push/i_entry : write one entry (never issued together with i_pop at count=2)
//   i_pop          : drop the head entry
//   i_clear        : empty the FIFO; wins over push and pop
//   o_count        : number of stored entries (0..2)
//   o_head         : oldest entry (storage is reset to zero)
module fetch_skid_fifo
    import riscv_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t slot_q [2];
    fetch_entry_t slot_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (i_push) wr_ptr_d = ~wr_ptr_q;
            if (i_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (i_push && !i_clear && (wr_ptr_q == 1'(gi)))
                    slot_d[gi] = i_entry;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) slot_q[gi] <= '0;
                else          slot_q[gi] <= slot_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_head  = slot_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// IF1/IF2 front end: owns the PC, issues reads to a synchronous instruction
// memory (1-cycle latency) and hands {pc, inst} to decode over valid/ready.
// A 2-entry skid FIFO plus credit-based issue guarantees no word is lost
// under back-pressure. EX redirects flush the buffer and the in-flight read.
// Optional build macro FETCH_MISALIGN_CHK_EN: misaligned redirect targets
// raise a sticky o_fetch_fault instead of being silently aligned.
// Ports:
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   o_en_inst, o_addr_inst     : imem read request and word address
//   i_rdata_inst               : imem data, valid one cycle after o_en_inst
//   o_id_valid, i_id_ready     : handshake toward IF2ID
//   o_id_pc, o_id_inst         : head entry
//   i_redirect, i_redirect_pc  : EX redirect request and byte target
//   o_fetch_fault              : misaligned redirect fault (0 unless macro set)
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          DATA_WIDTH          = 32,
    parameter int          INST_MEM_ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC            = RESET_PC_DEFAULT
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    output logic                           o_en_inst,
    output logic [INST_MEM_ADDR_WIDTH-3:0] o_addr_inst,
    input  logic [DATA_WIDTH-1:0]          i_rdata_inst,
    output logic                           o_id_valid,
    input  logic                           i_id_ready,
    output logic [DATA_WIDTH-1:0]          o_id_pc,
    output logic [DATA_WIDTH-1:0]          o_id_inst,
    input  logic                           i_redirect,
    input  logic [DATA_WIDTH-1:0]          i_redirect_pc,
    output logic                           o_fetch_fault
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] target_pc;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic                  redirect_bad;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    fetch_entry_t          head;
    fetch_entry_t          new_entry;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_pc    = i_redirect_pc;
    assign redirect_bad = i_redirect & (|i_redirect_pc[1:0]);
`else
    // Low target bits are simply discarded; the fault output stays low.
    assign target_pc    = {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign redirect_bad = 1'b0;
`endif

    assign fetch_pc = i_redirect ? target_pc : pc_q;

    // A redirect drops the returning word and its pop, so it never competes
    // with the buffer for the word being pushed or popped this cycle.
    assign push = inflight_q & ~i_redirect;
    assign pop  = o_id_valid & i_id_ready & ~i_redirect;

    // Credit check: entries held after this edge plus the new request must fit
    // in the two buffer slots. pop implies count>=1, so no underflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q};

    always_comb begin
        issue = 1'b0;
        if (i_redirect) issue = ~redirect_bad;   // buffer is emptied anyway
        else            issue = ~fault_q && ((occupancy - {2'b00, pop}) < 3'd2);
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        fault_d    = fault_q;
        if (issue) begin
            pc_d     = fetch_pc + DATA_WIDTH'(4);
            req_pc_d = fetch_pc;
        end else if (redirect_bad) begin
            pc_d = i_redirect_pc;
        end
`ifdef FETCH_MISALIGN_CHK_EN
        if (i_redirect) fault_d = redirect_bad;
`else
        fault_d = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= DATA_WIDTH'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            fault_q    <= fault_d;
        end
    end

    assign new_entry.pc   = req_pc_q;
    assign new_entry.inst = i_rdata_inst;

    fetch_skid_fifo u_skid_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_clear (i_redirect),
        .i_entry (new_entry),
        .o_count (count),
        .o_head  (head)
    );

    // Registers are already cleared while reset is low, but the credit check
    // would still see room; gate the request so nothing issues during reset.
    assign o_en_inst     = issue & i_rst_n;
    assign o_addr_inst   = fetch_pc[INST_MEM_ADDR_WIDTH-1:2];
    assign o_id_valid    = (count != 2'd0);
    assign o_id_pc       = head.pc;
    assign o_id_inst     = head.inst;
    assign o_fetch_fault = fault_q;

    // Byte-offset and out-of-range PC bits are intentionally not sent to memory.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[DATA_WIDTH-1:INST_MEM_ADDR_WIDTH],
                                 fetch_pc[1:0], i_redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous instruction memory model
// holding imem[i] = 32'h1000_0000 + i. Inputs change and outputs are checked
// on the falling clock edge (plus 1 time unit for combinational settling).
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        en_inst;
    logic [9:0]  addr_inst;
    logic [31:0] rdata_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks;
    int errors;

    logic [31:0] imem [1024];

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_en_inst     (en_inst),
        .o_addr_inst   (addr_inst),
        .i_rdata_inst  (rdata_inst),
        .o_id_valid    (id_valid),
        .i_id_ready    (id_ready),
        .o_id_pc       (id_pc),
        .o_id_inst     (id_inst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (en_inst) rdata_inst <= imem[addr_inst];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Head must be valid and carry the given PC and the word stored there.
    task automatic exp_head(input string tag, input logic [31:0] pc);
        logic [31:0] inst;
        inst = 32'h1000_0000 + {22'd0, pc[11:2]};
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, inst);
        $display("step %s: valid=%0d pc=%08h inst=%08h en=%0d addr=%03h fault=%0d",
                 tag, id_valid, id_pc, id_inst, en_inst, addr_inst, fetch_fault);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 + i;
        rdata_inst  = '0;
        rst_n       = 1'b0;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (2) next_cycle();
        #1;
        chk("rst_en", {31'd0, en_inst}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // Release: RESET_PC issued right away, valid two cycles later
        next_cycle(); rst_n = 1'b1; #1;
        chk("rel_en", {31'd0, en_inst}, 32'd1);
        chk("rel_addr", {22'd0, addr_inst}, 32'd0);
        next_cycle(); #1;
        chk("lat_valid0", {31'd0, id_valid}, 32'd0);
        chk("lat_addr", {22'd0, addr_inst}, 32'd1);
        next_cycle(); #1; exp_head("s0", 32'h0);
        next_cycle(); #1; exp_head("s4", 32'h4);

        // Stall for 5 cycles with 0x8 at the head
        next_cycle(); id_ready = 1'b0; #1;
        exp_head("st8", 32'h8);
        chk("st_en0", {31'd0, en_inst}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            exp_head("sth", 32'h8);
            chk("sth_en", {31'd0, en_inst}, 32'd0);
        end
        next_cycle(); id_ready = 1'b1; #1;
        exp_head("rl8", 32'h8);
        chk("rl_en", {31'd0, en_inst}, 32'd1);
        chk("rl_addr", {22'd0, addr_inst}, 32'h4);
        next_cycle(); #1; exp_head("rlC", 32'hC);
        next_cycle(); #1; exp_head("rl10", 32'h10);

        // Redirect while streaming
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h100; #1;
        exp_head("rd14", 32'h14);
        chk("rd_en", {31'd0, en_inst}, 32'd1);
        chk("rd_addr", {22'd0, addr_inst}, 32'h40);
        next_cycle(); redirect = 1'b0; #1;
        chk("rd_bubble", {31'd0, id_valid}, 32'd0);
        next_cycle(); #1; exp_head("rd100", 32'h100);

        // Redirect while the buffer is full
        next_cycle(); id_ready = 1'b0; #1;
        exp_head("fl104", 32'h104);
        chk("fl_en", {31'd0, en_inst}, 32'd0);
        next_cycle(); #1; exp_head("fl104h", 32'h104);
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk("frd_en", {31'd0, en_inst}, 32'd1);
        chk("frd_addr", {22'd0, addr_inst}, 32'h80);
        next_cycle(); redirect = 1'b0; #1;
        chk("frd_bubble", {31'd0, id_valid}, 32'd0);
        next_cycle(); #1;
        exp_head("f200s", 32'h200);
        chk("f200_en", {31'd0, en_inst}, 32'd0);
        next_cycle(); id_ready = 1'b1; #1; exp_head("f200", 32'h200);
        next_cycle(); #1; exp_head("f204", 32'h204);

        // Misaligned redirect target
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h102; #1;
        exp_head("m208", 32'h208);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_en", {31'd0, en_inst}, 32'd0);
`else
        chk("mis_en", {31'd0, en_inst}, 32'd1);
        chk("mis_addr", {22'd0, addr_inst}, 32'h40);
`endif
        next_cycle(); redirect = 1'b0; #1;
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_en2", {31'd0, en_inst}, 32'd0);
`else
        chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
`endif
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; #1;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_valid2", {31'd0, id_valid}, 32'd0);
        chk("mis_fault2", {31'd0, fetch_fault}, 32'd1);
`else
        exp_head("m100", 32'h100);
`endif
        chk("fix_en", {31'd0, en_inst}, 32'd1);
        chk("fix_addr", {22'd0, addr_inst}, 32'h80);
        next_cycle(); redirect = 1'b0; #1;
        chk("fix_valid", {31'd0, id_valid}, 32'd0);
        chk("fix_fault", {31'd0, fetch_fault}, 32'd0);

        // Reset with both buffer slots full
        next_cycle(); id_ready = 1'b0; #1;
        exp_head("x200", 32'h200);
        chk("x_en", {31'd0, en_inst}, 32'd0);
        next_cycle(); #1;
        exp_head("x200f", 32'h200);
        rst_n = 1'b0; #1;
        chk("mrst_valid", {31'd0, id_valid}, 32'd0);
        chk("mrst_pc", id_pc, 32'd0);
        chk("mrst_inst", id_inst, 32'd0);
        chk("mrst_en", {31'd0, en_inst}, 32'd0);
        next_cycle(); rst_n = 1'b1; id_ready = 1'b1; #1;
        chk("rs_en", {31'd0, en_inst}, 32'd1);
        chk("rs_addr", {22'd0, addr_inst}, 32'd0);
        next_cycle(); #1;
        chk("rs_valid0", {31'd0, id_valid}, 32'd0);

        // PC wrap at the top of the address space
        next_cycle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        exp_head("rs0", 32'h0);
        chk("wr_addr", {22'd0, addr_inst}, 32'h3FF);
        next_cycle(); redirect = 1'b0; #1;
        chk("wr_valid0", {31'd0, id_valid}, 32'd0);
        chk("wr_en", {31'd0, en_inst}, 32'd1);
        chk("wr_addr0", {22'd0, addr_inst}, 32'd0);
        next_cycle(); #1; exp_head("wrtop", 32'hFFFF_FFFC);
        next_cycle(); #1; exp_head("wr0", 32'h0);
        next_cycle(); #1; exp_head("wr4", 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
